// File: rtl/divider_pkg.sv
// divider_pkg: shared types and constants for the restoring divider.
// Imported by the control FSM and by anything that decodes its strobes.
package divider_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    SUB,
    TEST,
    DONE
  } state_t;

  localparam logic ALU_SUB = 1'b0;
  localparam logic ALU_ADD = 1'b1;

  localparam int DIV_N = 16;

endpackage

// File: rtl/divider_ctrl.sv
// divider_ctrl: sequencing FSM for a restoring-division datapath.
// Drives load/shift/alu strobes and a start/busy/done handshake.
module divider_ctrl
  import divider_pkg::*;
#(
  parameter int N     = DIV_N,
  parameter int CNT_W = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic divisor_zero,
  input  logic a_msb,
  output logic clr_a,
  output logic ld_q,
  output logic ld_m,
  output logic shl_aq,
  output logic ld_a,
  output logic alu_op,
  output logic set_q0,
  output logic q0_val,
  output logic busy,
  output logic done,
  output logic div_by_zero
);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             dz;
  logic             ld_a_r;
  logic             in_test;

  // TEST is the only state whose strobes follow a_msb combinationally.
  assign ld_a   = ld_a_r | (in_test & a_msb);
  assign alu_op = (in_test && a_msb) ? ALU_ADD : ALU_SUB;
  assign q0_val = in_test & ~a_msb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      dz          <= 1'b0;
      clr_a       <= 1'b0;
      ld_q        <= 1'b0;
      ld_m        <= 1'b0;
      shl_aq      <= 1'b0;
      ld_a_r      <= 1'b0;
      set_q0      <= 1'b0;
      in_test     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      clr_a   <= 1'b0;
      ld_q    <= 1'b0;
      ld_m    <= 1'b0;
      shl_aq  <= 1'b0;
      ld_a_r  <= 1'b0;
      set_q0  <= 1'b0;
      in_test <= 1'b0;
      done    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state       <= LOAD;
            dz          <= divisor_zero;
            div_by_zero <= 1'b0;
            busy        <= 1'b1;
            clr_a       <= 1'b1;
            ld_q        <= 1'b1;
            ld_m        <= 1'b1;
          end
        end
        LOAD: begin
          if (dz) begin
            // Skip the loop so count is already 0 back in IDLE.
            count       <= '0;
            state       <= DONE;
            done        <= 1'b1;
            div_by_zero <= 1'b1;
          end else begin
            count  <= CNT_W'(N);
            state  <= SHIFT;
            shl_aq <= 1'b1;
          end
        end
        SHIFT: begin
          state  <= SUB;
          ld_a_r <= 1'b1;
        end
        SUB: begin
          state   <= TEST;
          set_q0  <= 1'b1;
          in_test <= 1'b1;
        end
        TEST: begin
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state  <= SHIFT;
            shl_aq <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          count <= '0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_ctrl.sv
// tb_divider_ctrl: divider_ctrl driving a behavioural restoring datapath.
// Results are compared with plain integer division and fixed latencies.
module tb_divider_ctrl;

  localparam int N   = 16;
  localparam int LAT = 3 * N + 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] dividend_in = '0;
  logic [15:0] divisor_in = '0;
  logic        divisor_zero;
  logic        a_msb;
  logic        clr_a, ld_q, ld_m, shl_aq, ld_a, alu_op;
  logic        set_q0, q0_val, busy, done, div_by_zero;

  logic [16:0] a_reg = '0;
  logic [15:0] q_reg = '0;
  logic [15:0] m_reg = '0;

  int checks = 0;
  int errors = 0;
  logic prev_done = 1'b0;

  always #5 clk = ~clk;

  assign divisor_zero = (divisor_in == 16'd0);
  assign a_msb = a_reg[16];

  divider_ctrl #(.N(N), .CNT_W(5)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .divisor_zero(divisor_zero),
    .a_msb(a_msb),
    .clr_a(clr_a),
    .ld_q(ld_q),
    .ld_m(ld_m),
    .shl_aq(shl_aq),
    .ld_a(ld_a),
    .alu_op(alu_op),
    .set_q0(set_q0),
    .q0_val(q0_val),
    .busy(busy),
    .done(done),
    .div_by_zero(div_by_zero)
  );

  always @(posedge clk) begin
    if (clr_a) a_reg <= '0;
    if (ld_q) q_reg <= dividend_in;
    if (ld_m) m_reg <= divisor_in;
    if (shl_aq) {a_reg, q_reg} <= {a_reg[15:0], q_reg, 1'b0};
    if (ld_a)
      a_reg <= alu_op ? a_reg + {1'b0, m_reg} : a_reg - {1'b0, m_reg};
    if (set_q0) q_reg[0] <= q0_val;
  end

  always @(negedge clk) begin
    checks++;
    assert ($countones({clr_a, shl_aq, ld_a}) <= 1 && !(ld_q && shl_aq))
    else begin
      errors++;
      $error("FAIL strobe_excl: clr_a=%b shl_aq=%b ld_a=%b ld_q=%b",
             clr_a, shl_aq, ld_a, ld_q);
    end
    checks++;
    assert (!(prev_done && done))
    else begin
      errors++;
      $error("FAIL done_width: done high two cycles, expected one");
    end
    prev_done = done;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_div(input logic [15:0] dd, input logic [15:0] dv,
                        input int pulse_at);
    int cyc;
    bit seen;
    int exp_lat;
    exp_lat = (dv == 16'd0) ? 2 : LAT;
    @(negedge clk);
    dividend_in = dd;
    divisor_in = dv;
    start = 1'b1;
    cyc = 0;
    seen = 0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        chk("dbz_clear", 32'(div_by_zero), 0);
      end
      if (cyc == pulse_at) start = 1'b1;
      else if (pulse_at > 0 && cyc == pulse_at + 1) start = 1'b0;
      if (done) seen = 1;
      else chk("busy_run", 32'(busy), 1);
    end
    chk("done_seen", 32'(seen), 1);
    chk("latency", cyc, exp_lat);
    chk("busy_done", 32'(busy), 1);
    if (dv == 16'd0) begin
      chk("dz_q", 32'(q_reg), 32'(dd));
      chk("dz_a", 32'(a_reg), 0);
      chk("dz_flag", 32'(div_by_zero), 1);
    end else begin
      chk("quot", 32'(q_reg), 32'(dd / dv));
      chk("rem", 32'(a_reg), 32'(dd % dv));
      chk("dz_flag", 32'(div_by_zero), 0);
    end
    @(negedge clk);
    chk("done_drop", 32'(done), 0);
    chk("busy_drop", 32'(busy), 0);
  endtask

  initial begin
    int cyc;
    int ndone;
    logic [15:0] rd, rv;

    repeat (2) @(negedge clk);
    chk("rst_outs", 32'({clr_a, ld_q, ld_m, shl_aq, ld_a, alu_op,
                         set_q0, q0_val, busy, done, div_by_zero}), 0);
    rst_n = 1'b1;

    do_div(16'd100, 16'd7, 0);
    do_div(16'd65535, 16'd1, 0);
    do_div(16'd5, 16'd9, 0);

    do_div(16'd1234, 16'd0, 0);
    repeat (3) @(negedge clk);
    chk("dz_held", 32'(div_by_zero), 1);

    // A start pulse on the SHIFT of iteration 5 must be ignored.
    do_div(16'd100, 16'd7, 14);

    @(negedge clk);
    dividend_in = 16'd40000;
    divisor_in = 16'd3;
    start = 1'b1;
    cyc = 0;
    ndone = 0;
    while (ndone < 3 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        ndone++;
        chk("b2b_time", cyc, 32'(LAT + (LAT + 1) * (ndone - 1)));
        chk("b2b_quot", 32'(q_reg), 13333);
        chk("b2b_rem", 32'(a_reg), 1);
        if (ndone == 3) start = 1'b0;
      end
    end
    chk("b2b_count", ndone, 3);
    repeat (2) @(negedge clk);
    chk("b2b_idle", 32'(busy), 0);

    @(negedge clk);
    dividend_in = 16'd100;
    divisor_in = 16'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", 32'({clr_a, ld_q, ld_m, shl_aq, ld_a, alu_op,
                          set_q0, q0_val, busy, done, div_by_zero}), 0);
    repeat (4) begin
      @(negedge clk);
      chk("rst_no_done", 32'(done), 0);
    end
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      chk("post_rst_no_done", 32'(done), 0);
    end
    do_div(16'd100, 16'd7, 0);

    for (int i = 0; i < 10; i++) begin
      rd = 16'($urandom);
      if (i % 5 == 4) rv = 16'd0;
      else if (i % 3 == 0) rv = 16'($urandom_range(1, 255));
      else rv = 16'($urandom_range(1, 65535));
      do_div(rd, rv, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
